// File: rtl/tnn_pkg.sv
// Shared definitions for the temporal (race-logic) neural network blocks.
package tnn_pkg;

    // Shortest gamma that fits every finite value of a val_w-bit code plus one quiet tick.
    function automatic int gamma_len_min(input int val_w);
        return (1 << val_w);
    endfunction

endpackage

// File: rtl/gamma_counter.sv
// Free-running tick counter for one gamma cycle; reset parks it on the last (quiet) tick.
module gamma_counter #(
    parameter int GAMMA_LEN = 9,
    parameter int TW        = $clog2(GAMMA_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [TW-1:0] tick,
    output logic          is_last,
    output logic          next_is_zero
);

    localparam logic [TW-1:0] LAST = TW'(GAMMA_LEN - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= LAST;
        end else if (is_last) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    assign is_last      = (tick == LAST);
    assign next_is_zero = is_last;

endmodule

// File: rtl/spike_time_encoder.sv
// Turns a vector of binary values into race-logic falling edges, one vector per gamma cycle.
module spike_time_encoder
    import tnn_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int VAL_W     = 3,
    parameter int GAMMA_LEN = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*VAL_W-1:0]   in_data,
    output logic [N_CH-1:0]         spike_out,
    output logic                    gamma_start,
    output logic                    underrun
);

    localparam int              TW   = $clog2(GAMMA_LEN);
    localparam logic [VAL_W-1:0] MAXV = '1;
    localparam logic [TW-1:0]   LAST = TW'(GAMMA_LEN - 1);

    generate
        if (GAMMA_LEN < gamma_len_min(VAL_W)) begin : g_len_check
            $error("GAMMA_LEN too short for VAL_W");
        end
    endgenerate

    logic [TW-1:0]          tick;
    logic                   is_last;
    logic                   next_is_zero;
    logic [N_CH*VAL_W-1:0]  pend;
    logic                   pend_full;
    logic [N_CH*VAL_W-1:0]  active;
    logic [N_CH*VAL_W-1:0]  act_nxt;
    logic [TW-1:0]          nxt_tick;
    logic [N_CH-1:0]        spike_nxt;
    logic [VAL_W-1:0]       ch_val;
    logic                   xfer;

    gamma_counter #(
        .GAMMA_LEN (GAMMA_LEN),
        .TW        (TW)
    ) u_gamma_counter (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .is_last      (is_last),
        .next_is_zero (next_is_zero)
    );

    // Handshake: a vector moves on any posedge with in_valid && in_ready. in_ready
    // depends only on registered state, so in_valid may rise independently of it.
    assign in_ready = !pend_full || is_last;
    assign xfer     = in_valid && in_ready;

    // The active vector only swaps at the gamma boundary; a transfer in that same
    // cycle is newer than anything pending and wins.
    always_comb begin
        act_nxt = active;
        if (is_last) begin
            if (xfer) begin
                act_nxt = in_data;
            end else if (pend_full) begin
                act_nxt = pend;
            end else begin
                act_nxt = '1;
            end
        end
    end

    always_comb begin
        nxt_tick  = next_is_zero ? '0 : tick + TW'(1);
        spike_nxt = '1;
        ch_val    = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_val = act_nxt[i*VAL_W +: VAL_W];
            if ((ch_val != MAXV) && (nxt_tick >= TW'(ch_val)) && (nxt_tick != LAST)) begin
                spike_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= '0;
            pend_full   <= 1'b0;
            active      <= '1;
            spike_out   <= '1;
            gamma_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            active      <= act_nxt;
            spike_out   <= spike_nxt;
            gamma_start <= is_last;
            underrun    <= is_last && !xfer && !pend_full;
            if (is_last) begin
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend      <= in_data;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_time_encoder.sv
// Scoreboard bench for spike_time_encoder: accepted vectors queue up and are checked per gamma.
module tb_spike_time_encoder;

    localparam int N_CH      = 4;
    localparam int VAL_W     = 3;
    localparam int GAMMA_LEN = 9;
    localparam int LAST      = GAMMA_LEN - 1;
    localparam int W         = N_CH * VAL_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [N_CH-1:0] spike_out;
    logic          gamma_start;
    logic          underrun;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  cur;
    logic          exp_under;
    int            tb_tick;
    logic          rst_prev;

    spike_time_encoder #(
        .N_CH      (N_CH),
        .VAL_W     (VAL_W),
        .GAMMA_LEN (GAMMA_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .spike_out   (spike_out),
        .gamma_start (gamma_start),
        .underrun    (underrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s tick=%0d: got %0h expected %0h", tag, tb_tick, got, exp);
        end
    endtask

    function automatic logic [N_CH-1:0] exp_spike(input logic [W-1:0] v, input int j);
        logic [N_CH-1:0] r;
        int val;
        r = '1;
        for (int i = 0; i < N_CH; i++) begin
            val = int'(v[i*VAL_W +: VAL_W]);
            if (val != 7 && j >= val && j != LAST) r[i] = 1'b0;
        end
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    initial begin
        tb_tick   = LAST;
        cur       = '1;
        exp_under = 1'b0;
        rst_prev  = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rst_prev) begin
                check_eq("rst_spike", 32'(spike_out), 32'hF);
                check_eq("rst_gamma_start", 32'(gamma_start), 0);
                check_eq("rst_underrun", 32'(underrun), 0);
            end
            exp_q.delete();
            cur       = '1;
            exp_under = 1'b0;
            tb_tick   = LAST;
            rst_prev  = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (tb_tick == 0) begin
                if (exp_q.size() > 0) begin
                    cur       = exp_q.pop_front();
                    exp_under = 1'b0;
                end else begin
                    cur       = '1;
                    exp_under = 1'b1;
                end
            end
            check_eq("spike_out", 32'(spike_out), 32'(exp_spike(cur, tb_tick)));
            check_eq("gamma_start", 32'(gamma_start), 32'(tb_tick == 0));
            check_eq("underrun", 32'(underrun), 32'(tb_tick == 0 && exp_under));
            check_eq("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || tb_tick == LAST));
            if (in_valid && in_ready) begin
                if (tb_tick == LAST) exp_q.delete();
                exp_q.push_back(in_data);
            end
            tb_tick = (tb_tick == LAST) ? 0 : tb_tick + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] v);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int c = 0; c < 4 * GAMMA_LEN && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) check_eq("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int j);
        for (int c = 0; c < 2 * GAMMA_LEN; c++) begin
            @(posedge clk);
            #1;
            if (tb_tick == j) break;
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i*VAL_W +: VAL_W] = VAL_W'($urandom_range(0, 7));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * GAMMA_LEN) @(posedge clk);
        #1;

        // value table vector {3,0,5,7}, accepted mid-gamma
        wait_tick(4);
        send({3'd3, 3'd0, 3'd5, 3'd7});
        in_valid = 1'b0;
        repeat (2 * GAMMA_LEN) @(posedge clk);
        #1;

        // sustained stream
        send(rand_vec());
        send(rand_vec());
        send(rand_vec());
        in_valid = 1'b0;
        repeat (2 * GAMMA_LEN) @(posedge clk);
        #1;

        // all-infinity vector
        wait_tick(2);
        send({N_CH{3'd7}});
        in_valid = 1'b0;
        repeat (2 * GAMMA_LEN) @(posedge clk);
        #1;

        // reset mid-gamma with a vector active and another pending
        wait_tick(LAST);
        send({N_CH{3'd1}});
        in_valid = 1'b0;
        wait_tick(2);
        send(rand_vec());
        in_valid = 1'b0;
        wait_tick(4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * GAMMA_LEN) @(posedge clk);
        #1;

        // equal values: all lines must fall together
        wait_tick(5);
        send({N_CH{3'd2}});
        in_valid = 1'b0;
        repeat (2 * GAMMA_LEN) @(posedge clk);
        #1;

        // random vectors at random ticks
        for (int k = 0; k < 8; k++) begin
            wait_tick($urandom_range(0, LAST));
            send(rand_vec());
            in_valid = 1'b0;
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end

        repeat (3 * GAMMA_LEN) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
